// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of one pipelined adder, with tagged in-order responses
module add_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 16,
    parameter int ADD_LATENCY = 1,
    parameter int ID_W        = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH:0]           add_c,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH:0]           rsp_data,
    output logic                     busy
);
    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        winner;
    logic                   found;
    logic                   grant;
    logic [ADD_LATENCY-1:0] tag_v;
    logic [ID_W-1:0]        tag_id [ADD_LATENCY];
    int                     idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign grant     = en && !rst && found;
    assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
    assign add_a     = grant ? req_a[int'(winner)*WIDTH +: WIDTH] : '0;
    assign add_b     = grant ? req_b[int'(winner)*WIDTH +: WIDTH] : '0;
    assign busy      = !rst && (|tag_v || |rsp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            tag_v     <= '0;
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            for (int k = 0; k < ADD_LATENCY; k++) tag_id[k] <= '0;
        end else begin
            if (grant) ptr <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
            tag_v[0]  <= grant;
            tag_id[0] <= winner;
            for (int k = 1; k < ADD_LATENCY; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            rsp_valid <= tag_v[ADD_LATENCY-1] ? (NUM_REQ'(1) << tag_id[ADD_LATENCY-1]) : '0;
            if (tag_v[ADD_LATENCY-1]) begin
                rsp_id   <= tag_id[ADD_LATENCY-1];
                rsp_data <= add_c;
            end
        end
    end
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed table plus model-checked random traffic for add_arbiter
module tb_add_arbiter;
    localparam int N = 4, W = 16, L = 1, IW = 2;

    logic           clk = 1'b0;
    logic           rst, en;
    logic [N-1:0]   req_valid, req_ready, rsp_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   add_a, add_b;
    logic [W:0]     add_c, rsp_data;
    logic [IW-1:0]  rsp_id;
    logic           busy;

    int checks = 0;
    int failures = 0;

    add_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADD_LATENCY(L), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_c(add_c),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // shared adder: registered, one-cycle latency
    always_ff @(posedge clk) add_c <= {1'b0, add_a} + {1'b0, add_b};

    typedef struct {
        logic       e;
        logic [3:0] v;
        logic [3:0] rdy;
        logic [3:0] rsp;
        logic       bsy;
    } vec_t;

    typedef struct {
        int         id;
        logic [W:0] sum;
        int         due;
    } exp_t;

    vec_t tbl [22];
    exp_t q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic next_row();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr(input int p, input logic [3:0] v);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    initial begin
        int id, grants, rsps, last_rsp, m_ptr, w;
        logic [W-1:0] oa, ob;
        logic g;

        tbl[0]  = '{1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b0};
        tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        tbl[2]  = '{1'b1, 4'b1111, 4'b0001, 4'b1000, 1'b1};
        tbl[3]  = '{1'b1, 4'b1111, 4'b0010, 4'b0000, 1'b1};
        tbl[4]  = '{1'b1, 4'b1111, 4'b0100, 4'b0001, 1'b1};
        tbl[5]  = '{1'b1, 4'b1111, 4'b1000, 4'b0010, 1'b1};
        tbl[6]  = '{1'b1, 4'b1111, 4'b0001, 4'b0100, 1'b1};
        tbl[7]  = '{1'b1, 4'b1111, 4'b0010, 4'b1000, 1'b1};
        tbl[8]  = '{1'b1, 4'b1111, 4'b0100, 4'b0001, 1'b1};
        tbl[9]  = '{1'b1, 4'b1111, 4'b1000, 4'b0010, 1'b1};
        tbl[10] = '{1'b1, 4'b1010, 4'b0010, 4'b0100, 1'b1};
        tbl[11] = '{1'b1, 4'b1010, 4'b1000, 4'b1000, 1'b1};
        tbl[12] = '{1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b1};
        tbl[13] = '{1'b1, 4'b1111, 4'b0001, 4'b1000, 1'b1};
        tbl[14] = '{1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b1};
        tbl[15] = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b1};
        tbl[16] = '{1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b1};
        tbl[17] = '{1'b1, 4'b0110, 4'b0010, 4'b0001, 1'b1};
        tbl[18] = '{1'b1, 4'b0100, 4'b0100, 4'b0001, 1'b1};
        tbl[19] = '{1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b1};
        tbl[20] = '{1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b1};
        tbl[21] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        rst = 1'b1; en = 1'b1; req_valid = 4'hF; req_a = '1; req_b = '1;
        next_row();
        next_row();
        chk("rst_ready", req_ready, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);

        rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        next_row();
        req_a[2*W +: W] = 16'hFFFF; req_b[2*W +: W] = 16'h0001; req_valid = 4'b0100;
        #1;
        chk("carry_ready", req_ready, 4'b0100);
        chk("carry_add_a", add_a, 16'hFFFF);
        chk("carry_add_b", add_b, 16'h0001);
        next_row();
        req_valid = '0;
        chk("carry_rsp_early", rsp_valid, 0);
        chk("carry_busy", busy, 1);
        next_row();
        chk("carry_rsp_valid", rsp_valid, 4'b0100);
        chk("carry_rsp_id", rsp_id, 2);
        chk("carry_rsp_data", rsp_data, 17'h10000);
        next_row();
        chk("carry_rsp_once", rsp_valid, 0);
        chk("carry_idle", busy, 0);

        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(i * 100);
            req_b[i*W +: W] = 16'd7;
        end
        for (int r = 0; r < 22; r++) begin
            en = tbl[r].e; req_valid = tbl[r].v;
            #1;
            chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].rdy);
            chk($sformatf("tbl%0d_rsp_valid", r), rsp_valid, tbl[r].rsp);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].bsy);
            if (tbl[r].rsp != 0) begin
                id = 0;
                for (int i = 0; i < N; i++) if (tbl[r].rsp[i]) id = i;
                chk($sformatf("tbl%0d_rsp_id", r), rsp_id, id);
                chk($sformatf("tbl%0d_rsp_data", r), rsp_data, id * 100 + 7);
            end
            next_row();
        end

        grants = 0; rsps = 0; last_rsp = -1;
        for (int r = 0; r < 8; r++) begin
            en = (r < 4); req_valid = 4'hF;
            #1;
            if (req_ready != 0) grants++;
            if (rsp_valid != 0) begin
                rsps++;
                last_rsp = r;
            end
            if (r == 5) chk("drain_busy_last", busy, 1);
            if (r == 6) chk("drain_busy_fall", busy, 0);
            next_row();
        end
        chk("drain_grants", grants, 4);
        chk("drain_rsps", rsps, 4);
        chk("drain_last_rsp", last_rsp, 5);

        en = 1'b1; req_valid = 4'hF;
        #1;
        chk("rstmid_g0", req_ready, 4'b1000);
        next_row();
        #1;
        chk("rstmid_g1", req_ready, 4'b0001);
        next_row();
        rst = 1'b1;
        #1;
        chk("rstmid_ready", req_ready, 0);
        chk("rstmid_busy", busy, 0);
        next_row();
        rst = 1'b0; req_valid = '0;
        #1;
        chk("rstmid_rsp_valid", rsp_valid, 0);
        chk("rstmid_rsp_data", rsp_data, 0);
        chk("rstmid_rsp_id", rsp_id, 0);
        chk("rstmid_idle", busy, 0);
        next_row();
        req_valid = 4'hF;
        #1;
        chk("rstmid_ptr0", req_ready, 4'b0001);
        chk("rstmid_no_rsp", rsp_valid, 0);
        next_row();

        rst = 1'b1; req_valid = '0;
        next_row();
        rst = 1'b0;
        next_row();
        m_ptr = 0;
        for (int r = 0; r < 1004; r++) begin
            en = ($urandom_range(0, 9) != 0);
            req_valid = (r < 1000) ? 4'($urandom) : 4'b0;
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = W'($urandom);
                req_b[i*W +: W] = W'($urandom);
            end
            #1;
            w = rr(m_ptr, req_valid);
            g = en && (w >= 0);
            chk("rand_ready", req_ready, g ? (32'd1 << w) : 32'd0);
            if (q.size() > 0 && q[0].due == r) begin
                chk("rand_rsp_valid", rsp_valid, 32'd1 << q[0].id);
                chk("rand_rsp_id", rsp_id, q[0].id);
                chk("rand_rsp_data", rsp_data, q[0].sum);
                void'(q.pop_front());
            end else begin
                chk("rand_rsp_none", rsp_valid, 0);
            end
            if (g) begin
                oa = req_a[w*W +: W];
                ob = req_b[w*W +: W];
                q.push_back('{w, {1'b0, oa} + {1'b0, ob}, r + 2});
                m_ptr = (w + 1) % N;
            end
            next_row();
        end
        chk("rand_queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
- Shares one pipelined adder instance (my_add: registered, ADD_LATENCY-cycle sum) between NUM_REQ requesters.
- Each cycle, grants at most one pending request using round-robin and drives the winner's operands onto the adder.
- Tracks the issuing requester through a tag pipeline matched to the adder latency.
- Returns each sum to its requester with a one-hot response valid.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- WIDTH, 16: operand width; the sum is WIDTH+1 bits.
- ADD_LATENCY, 1: clock edges from the adder sampling a/b to c holding the sum, >=1.
- ID_W, 2: requester index width, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  when low, no new grants; in-flight operations still complete.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_a  in  NUM_REQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand b; same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant; the handshake completes on the edge where valid & ready.
- add_a  out  WIDTH  operand a to the shared adder.
- add_b  out  WIDTH  operand b to the shared adder.
- add_c  in  WIDTH+1  sum from the shared adder.
- rsp_valid  out  NUM_REQ  one-hot: result for requester i is valid this cycle.
- rsp_id  out  ID_W  index of the requester being answered.
- rsp_data  out  WIDTH+1  sum being returned.
- busy  out  1  high while any operation is in flight or a response is pending.

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high.
- Reset state:
  - ptr=0, all tag stages invalid.
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - While rst=1: req_ready=0, add_a=0, add_b=0, busy=0.
- Grant logic (combinational):
  - Winner = first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NUM_REQ.
  - req_ready = onehot(winner) when en=1, rst=0 and any req_valid=1; otherwise req_ready=0.
  - At most one bit of req_ready is set.
  - req_ready never asserts for a requester whose req_valid=0.
- Operand mux:
  - add_a/add_b = req_a/req_b slices of the winner while a grant is active.
  - add_a/add_b = 0 when there is no grant.
- Round-robin pointer: on each issue edge, ptr <= (winner+1) mod NUM_REQ. With no grant, ptr holds.
- Tag pipeline (ADD_LATENCY stages of {valid, id}):
  - Issue edge: tag[0] <= {1, winner}. Non-issue edge: tag[0] <= {0, x}.
  - tag[k] <= tag[k-1] every edge; the pipeline never stalls.
- Response register, on every edge:
  - rsp_valid <= tag[L-1].valid ? onehot(tag[L-1].id) : 0.
  - rsp_id <= tag[L-1].id when tag[L-1] is valid, else holds.
  - rsp_data <= add_c when tag[L-1] is valid, else holds.
- Latency:
  - A handshake on edge k gives rsp_valid high for exactly one cycle, starting after edge k+ADD_LATENCY.
  - Throughput is one operation per cycle; responses return in issue order.
- No response backpressure: a requester must accept rsp_valid in the cycle it is presented.
- Arithmetic: the adder computes the full WIDTH+1-bit sum with the carry preserved; this block does no arithmetic.
- busy = any tag valid OR any rsp_valid bit set.
- Boundary conditions:
  - All NUM_REQ requesters continuously valid: grants rotate 0,1,2,3,0,... with exactly one grant per cycle.
  - Single requester held valid: granted every cycle; ptr tracks winner+1.
  - en deasserted mid-stream: grants stop the same cycle; in-flight tags drain, and busy falls after the last response.
  - req_valid dropped in the same cycle it would win: no grant to that requester, next candidate considered.
  - rst asserted mid-operation: all in-flight tags are discarded and no response is emitted for them; ptr returns to 0.
  - Winner's req_valid rises in the same cycle another requester's falls: arbitration uses current-cycle values only.

Test Plan:
- Reset, then requester 2 alone with a=16'hFFFF, b=16'h0001 -> req_ready=4'b0100 in the same cycle; ADD_LATENCY+1 edges later rsp_valid=4'b0100, rsp_id=2, rsp_data=17'h10000.
- All four requesters valid for 8 cycles, requester i using a=i*100, b=7 -> grant order 0,1,2,3,0,1,2,3; responses in the same order with data i*100+7; no gaps.
- Requesters 1 and 3 valid after requester 3 was the last grant (ptr=0) -> requester 1 granted first, then 3; ptr ends at 0.
- Four back-to-back ops, then en=0 -> no further grants; exactly four responses; busy drops one cycle after the last rsp_valid.
- rst pulsed one cycle after two issues -> no rsp_valid for either; rsp_data=0; next grant goes to requester 0 first.
- Random stress, 1000 cycles, with $urandom operands and valid patterns checked against a reference model -> every response matches a+b of its request, in order, with zero mismatches.
